// File: rtl/conv_z_streamer.sv
// conv_z_streamer: drains the Z result memory onto a valid/ready stream.
// After the convolver signals done, Z[0..sizeZ-1] is read through a
// synchronous-read port. Each sample is delivered as one beat, and the final
// beat carries a last marker. A 2-entry buffer covers the one-cycle read
// latency, so the block sustains one beat per cycle under back-pressure.
// Optional build macro: CONV_Z_STREAM_SAT_EN clamps output data to SAT_MAX.
module conv_z_streamer #(
    parameter int          DATA_WIDTH_OUT    = 16,
    parameter int          ADDRESS_WIDTH_OUT = 6,
    parameter int unsigned SAT_MAX           = 4095
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done_i,
    input  logic [ADDRESS_WIDTH_OUT-1:0] size_z_i,
    output logic [ADDRESS_WIDTH_OUT-1:0] mem_z_addr_o,
    output logic                         mem_z_rd_o,
    input  logic [DATA_WIDTH_OUT-1:0]    mem_z_data_i,
    output logic [DATA_WIDTH_OUT-1:0]    m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         m_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

`ifdef CONV_Z_STREAM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    localparam logic [DATA_WIDTH_OUT-1:0] SAT_VAL = DATA_WIDTH_OUT'(SAT_MAX);

    logic [1:0]                   state_reg;
    logic [ADDRESS_WIDTH_OUT-1:0] size_reg;
    logic [ADDRESS_WIDTH_OUT-1:0] rd_idx_reg;
    logic [ADDRESS_WIDTH_OUT-1:0] beat_idx_reg;
    logic [ADDRESS_WIDTH_OUT-1:0] addr_reg;
    logic                         inflight_reg;
    logic [1:0]                   cnt_reg;
    logic                         wr_ptr_reg;
    logic                         rd_ptr_reg;
    logic [DATA_WIDTH_OUT-1:0]    buf_q [2];

    logic                         in_stream;
    logic [1:0]                   occ_total;
    logic                         rd_issue;
    logic                         valid;
    logic                         pop;
    logic                         pop_buf;
    logic                         push;
    logic                         last_beat;
    logic [DATA_WIDTH_OUT-1:0]    head;

    // Read issue, buffer bookkeeping and stream-side decode.
    // Returning read data counts as a buffer entry: when the buffer is empty
    // it is presented directly, which gives first valid one cycle after issue.
    always_comb begin
        in_stream = (state_reg == ST_STREAM);
        occ_total = cnt_reg + {1'b0, inflight_reg};
        rd_issue  = in_stream && (rd_idx_reg < size_reg) && (occ_total < 2'd2);
        valid     = in_stream && (occ_total != 2'd0);
        pop       = valid && m_ready_i;
        pop_buf   = pop && (cnt_reg != 2'd0);
        push      = inflight_reg && !(pop && (cnt_reg == 2'd0));
        last_beat = (beat_idx_reg == (size_reg - ADDRESS_WIDTH_OUT'(1)));
        head      = (cnt_reg != 2'd0) ? buf_q[rd_ptr_reg] : mem_z_data_i;
    end

    // Output drive; the clamp only affects the outgoing value, never the buffer.
    always_comb begin
        mem_z_rd_o   = rd_issue;
        mem_z_addr_o = rd_issue ? rd_idx_reg : addr_reg;
        m_valid_o    = valid;
        m_last_o     = valid && last_beat;
        m_data_o     = '0;
        if (valid) begin
            m_data_o = (SAT_EN && (head > SAT_VAL)) ? SAT_VAL : head;
        end
        busy_o       = in_stream;
        done_o       = (state_reg == ST_FINISH);
    end

    // Frame control: accept done, count reads and beats, finish after last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            size_reg     <= '0;
            rd_idx_reg   <= '0;
            beat_idx_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (done_i) begin
                        size_reg     <= size_z_i;
                        rd_idx_reg   <= '0;
                        beat_idx_reg <= '0;
                        state_reg    <= (size_z_i == '0) ? ST_FINISH : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (rd_issue) begin
                        rd_idx_reg <= rd_idx_reg + ADDRESS_WIDTH_OUT'(1);
                    end
                    if (pop) begin
                        beat_idx_reg <= beat_idx_reg + ADDRESS_WIDTH_OUT'(1);
                        if (last_beat) begin
                            state_reg <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Address hold register so the RAM address is stable between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg <= '0;
        end else if (rd_issue) begin
            addr_reg <= rd_idx_reg;
        end
    end

    // In-flight flag, occupancy count and buffer pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_reg <= 1'b0;
            cnt_reg      <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            inflight_reg <= rd_issue;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_buf) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop_buf})
                2'b10:   cnt_reg <= cnt_reg + 2'd1;
                2'b01:   cnt_reg <= cnt_reg - 2'd1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Buffer storage: each entry captures returning read data when it is
    // the write target and the beat was not consumed straight from the RAM.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_WIDTH_OUT-1:0] entry_reg;

            // Entry write on push to this slot.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= mem_z_data_i;
                end
            end

            assign buf_q[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: tb/tb_conv_z_streamer.sv
// Self-checking bench for conv_z_streamer: a table-driven single frame with
// exact cycle expectations, followed by directed sequences for back-pressure,
// empty frames, ignored done pulses, mid-frame reset and output clamping.
module tb_conv_z_streamer;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk;
    logic          rst;
    logic          done_i;
    logic [AW-1:0] size_z_i;
    logic [AW-1:0] mem_z_addr_o;
    logic          mem_z_rd_o;
    logic [DW-1:0] mem_z_data_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_o;
    logic          busy_o;
    logic          done_o;

    conv_z_streamer #(
        .DATA_WIDTH_OUT   (DW),
        .ADDRESS_WIDTH_OUT(AW),
        .SAT_MAX          (4095)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .done_i      (done_i),
        .size_z_i    (size_z_i),
        .mem_z_addr_o(mem_z_addr_o),
        .mem_z_rd_o  (mem_z_rd_o),
        .mem_z_data_i(mem_z_data_i),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_last_o    (m_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Z RAM model with one-cycle registered read.
    logic [DW-1:0] ram [64];
    always @(posedge clk) begin
        if (mem_z_rd_o) mem_z_data_i <= ram[mem_z_addr_o];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stream monitor, sampled on the falling edge.
    int            rd_cnt [64];
    int            issued;
    int            done_cnt;
    logic [DW-1:0] beat_q [$];
    logic          last_q [$];
    logic [DW-1:0] exp_q  [$];
    bit            mon_chk;
    bit            stall_prev;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_z_rd_o) begin
                rd_cnt[mem_z_addr_o]++;
                issued++;
            end
            if (m_valid_o && m_ready_i) begin
                beat_q.push_back(m_data_o);
                last_q.push_back(m_last_o);
            end
            if (done_o) done_cnt++;
            if (mon_chk) begin
                if (stall_prev) begin
                    chk("stall_valid", 32'(m_valid_o), 32'd1);
                    chk("stall_data", 32'(m_data_o), 32'(prev_data));
                    chk("stall_last", 32'(m_last_o), 32'(prev_last));
                end
                if (issued - beat_q.size() > 2) begin
                    chk("outstanding", 32'(issued - beat_q.size()), 32'd2);
                end
            end
            stall_prev = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic clear_mon();
        for (int i = 0; i < 64; i++) rd_cnt[i] = 0;
        issued   = 0;
        done_cnt = 0;
        beat_q.delete();
        last_q.delete();
        exp_q.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done(input string name, input int max_cycles);
        int k = 0;
        while (done_cnt == 0 && k < max_cycles) begin
            tick();
            k++;
        end
        chk({name, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        tick();
        tick();
    endtask

    task automatic chk_beats(input string name);
        chk({name, "_beat_count"}, 32'(beat_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
            chk($sformatf("%s_data[%0d]", name, i), 32'(beat_q[i]), 32'(exp_q[i]));
            chk($sformatf("%s_last[%0d]", name, i), 32'(last_q[i]), 32'(i == exp_q.size() - 1));
        end
    endtask

    typedef struct {
        logic          done;
        logic [AW-1:0] size;
        logic          ready;
        logic          rd;
        logic [AW-1:0] addr;
        logic          valid;
        logic [DW-1:0] data;
        logic          last;
        logic          busy;
        logic          dn;
    } vec_t;

    vec_t tv [8];
    int   pat [8];
    int   done_at;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                  done size rdy  rd addr val data last busy dn
        tv[0] = '{1'b1, 6'd4, 1'b1, 1'b0, 6'd0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 6'd0, 1'b1, 1'b1, 6'd0, 1'b0, 16'd0,  1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 6'd0, 1'b1, 1'b1, 6'd1, 1'b1, 16'd10, 1'b0, 1'b1, 1'b0};
        tv[3] = '{1'b0, 6'd0, 1'b1, 1'b1, 6'd2, 1'b1, 16'd20, 1'b0, 1'b1, 1'b0};
        tv[4] = '{1'b0, 6'd0, 1'b1, 1'b1, 6'd3, 1'b1, 16'd30, 1'b0, 1'b1, 1'b0};
        tv[5] = '{1'b0, 6'd0, 1'b1, 1'b0, 6'd3, 1'b1, 16'd40, 1'b1, 1'b1, 1'b0};
        tv[6] = '{1'b0, 6'd0, 1'b1, 1'b0, 6'd3, 1'b0, 16'd0,  1'b0, 1'b0, 1'b1};
        tv[7] = '{1'b0, 6'd0, 1'b1, 1'b0, 6'd3, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0};
        pat   = '{1, 0, 0, 1, 0, 1, 1, 1};

        for (int i = 0; i < 64; i++) ram[i] = '0;
        rst       = 1'b0;
        done_i    = 1'b0;
        size_z_i  = '0;
        m_ready_i = 1'b0;
        mon_chk   = 1'b0;
        clear_mon();

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        chk("rst_rd", 32'(mem_z_rd_o), 32'd0);
        chk("rst_addr", 32'(mem_z_addr_o), 32'd0);
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_data", 32'(m_data_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Frame of 4 with exact per-cycle expectations.
        ram[0] = 16'd10; ram[1] = 16'd20; ram[2] = 16'd30; ram[3] = 16'd40;
        for (int i = 0; i < 8; i++) begin
            done_i    = tv[i].done;
            size_z_i  = tv[i].size;
            m_ready_i = tv[i].ready;
            @(negedge clk);
            chk($sformatf("t1_rd[%0d]", i), 32'(mem_z_rd_o), 32'(tv[i].rd));
            chk($sformatf("t1_addr[%0d]", i), 32'(mem_z_addr_o), 32'(tv[i].addr));
            chk($sformatf("t1_valid[%0d]", i), 32'(m_valid_o), 32'(tv[i].valid));
            if (tv[i].valid) chk($sformatf("t1_data[%0d]", i), 32'(m_data_o), 32'(tv[i].data));
            chk($sformatf("t1_last[%0d]", i), 32'(m_last_o), 32'(tv[i].last));
            chk($sformatf("t1_busy[%0d]", i), 32'(busy_o), 32'(tv[i].busy));
            chk($sformatf("t1_done[%0d]", i), 32'(done_o), 32'(tv[i].dn));
            @(posedge clk);
            #1;
        end

        // Back-pressure on a frame of 6.
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            ram[i] = 16'(i * 7 + 1);
            exp_q.push_back(16'(i * 7 + 1));
        end
        ram[6] = 16'hdead;
        mon_chk = 1'b1;
        done_i = 1'b1;
        size_z_i = 6'd6;
        for (int c = 0; c < 40 && done_cnt == 0; c++) begin
            m_ready_i = (c < 8) ? pat[c][0] : 1'b1;
            tick();
            done_i = 1'b0;
            size_z_i = '0;
        end
        chk("t2_done_seen", 32'(done_cnt), 32'd1);
        tick();
        mon_chk = 1'b0;
        m_ready_i = 1'b1;
        chk_beats("t2");
        for (int i = 0; i < 6; i++) chk($sformatf("t2_reads[%0d]", i), 32'(rd_cnt[i]), 32'd1);
        chk("t2_reads_beyond", 32'(rd_cnt[6]), 32'd0);

        // Empty frame.
        clear_mon();
        done_i = 1'b1;
        size_z_i = 6'd0;
        @(negedge clk);
        chk("t3_busy_c0", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        done_i = 1'b0;
        @(negedge clk);
        chk("t3_done_c1", 32'(done_o), 32'd1);
        chk("t3_busy_c1", 32'(busy_o), 32'd0);
        chk("t3_valid_c1", 32'(m_valid_o), 32'd0);
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("t3_done_count", 32'(done_cnt), 32'd1);
        chk("t3_reads", 32'(issued), 32'd0);
        chk("t3_beats", 32'(beat_q.size()), 32'd0);

        // done_i during a frame of 5 is ignored.
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            ram[i] = 16'(200 + i);
            exp_q.push_back(16'(200 + i));
        end
        done_i = 1'b1;
        size_z_i = 6'd5;
        tick();
        done_i = 1'b0;
        size_z_i = '0;
        tick();
        done_i = 1'b1;
        size_z_i = 6'd2;
        tick();
        done_i = 1'b0;
        size_z_i = '0;
        done_at = -1;
        for (int c = 3; c < 30 && done_at < 0; c++) begin
            @(negedge clk);
            if (done_o) done_at = c;
            @(posedge clk);
            #1;
        end
        chk("t4_done_cycle", 32'(done_at), 32'd7);
        tick();
        tick();
        tick();
        chk("t4_done_count", 32'(done_cnt), 32'd1);
        chk_beats("t4");
        chk("t4_reads", 32'(issued), 32'd5);

        // Reset in the middle of a frame of 8, then a fresh frame of 3.
        clear_mon();
        for (int i = 0; i < 8; i++) ram[i] = 16'(300 + i);
        done_i = 1'b1;
        size_z_i = 6'd8;
        tick();
        done_i = 1'b0;
        size_z_i = '0;
        tick();
        tick();
        tick();
        chk("t5_beats_before_rst", 32'(beat_q.size()), 32'd2);
        rst = 1'b0;
        #1;
        chk("t5_rst_rd", 32'(mem_z_rd_o), 32'd0);
        chk("t5_rst_addr", 32'(mem_z_addr_o), 32'd0);
        chk("t5_rst_valid", 32'(m_valid_o), 32'd0);
        chk("t5_rst_data", 32'(m_data_o), 32'd0);
        chk("t5_rst_last", 32'(m_last_o), 32'd0);
        chk("t5_rst_busy", 32'(busy_o), 32'd0);
        chk("t5_rst_done", 32'(done_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_no_done_after_rst", 32'(done_cnt), 32'd0);
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            ram[i] = 16'(400 + i);
            exp_q.push_back(16'(400 + i));
        end
        done_i = 1'b1;
        size_z_i = 6'd3;
        tick();
        done_i = 1'b0;
        size_z_i = '0;
        run_to_done("t5", 20);
        chk_beats("t5");
        chk("t5_addr0_read", 32'(rd_cnt[0]), 32'd1);
        chk("t5_reads", 32'(issued), 32'd3);
        chk("t5_done_count", 32'(done_cnt), 32'd1);

        // Output clamp.
        clear_mon();
        ram[0] = 16'd5000;
        ram[1] = 16'd100;
`ifdef CONV_Z_STREAM_SAT_EN
        exp_q.push_back(16'd4095);
`else
        exp_q.push_back(16'd5000);
`endif
        exp_q.push_back(16'd100);
        done_i = 1'b1;
        size_z_i = 6'd2;
        tick();
        done_i = 1'b0;
        size_z_i = '0;
        run_to_done("t6", 20);
        chk_beats("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
